// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Owner/state encodings are also used by the bench through DBG_STATE.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_DEPTH   = 2048;
  localparam int DEF_IM_BASE = 1024;

  // A store may only land below the instruction image and inside the array.
  function automatic logic store_blocked(input logic [31:0] addr,
                                         input int          im_base,
                                         input int          depth);
    return (addr >= 32'(im_base)) || (addr >= 32'(depth));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bus between the two MIPS requesters, the arbiter and
// the unified memory.
interface mem_arbiter_if;
  // Handshake: a requester raises REQ with ADDR/WE/WD and holds all of them
  // stable until the single-cycle ACK; RD is valid in the ACK cycle and then
  // held. REQ still high after ACK is a fresh request.
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_ACK;
  logic [31:0] IF_RD;

  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WD;
  logic        D_ACK;
  logic [31:0] D_RD;
  logic        D_ERR;

  logic        MWE;
  logic [31:0] MRA;
  logic [31:0] MWD;
  logic [31:0] MRD;

  modport master (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WD,
    input  IF_ACK, IF_RD, D_ACK, D_RD, D_ERR
  );

  modport slave (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WD, MRD,
    output IF_ACK, IF_RD, D_ACK, D_RD, D_ERR, MWE, MRA, MWD
  );

  modport mem (
    input  MWE, MRA, MWD,
    output MRD
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational owner selection. With rr_ptr tied to OWN_IF this degenerates
// to fixed D-over-IF priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t rr_ptr,
  output logic   valid,
  output owner_t owner
);

  always_comb begin
    valid = if_req | d_req;
    owner = OWN_IF;
    // D loses a tie only when it was the previous grantee.
    if (d_req && !(if_req && (rr_ptr == OWN_D))) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter / access sequencer for the multicycle MIPS core.
// Define MEM_ARBITER_RR_EN for round-robin ties; default is fixed D-over-IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int IM_BASE     = DEF_IM_BASE,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus,
  output state_t       DBG_STATE
);

  localparam int             WCW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WC_INIT = WCW'(WAIT_CYCLES - 1);

  state_t         state;
  owner_t         owner;
  logic           we_q;
  logic           blk_q;
  logic           oor_q;
  logic [WCW-1:0] wcnt;
  logic           if_ack_q;
  logic           d_ack_q;
  logic           d_err_q;
  logic           mwe_q;
  logic [31:0]    if_rd_q;
  logic [31:0]    d_rd_q;
  logic [31:0]    mra_q;
  logic [31:0]    mwd_q;

  owner_t         rr_ptr;
  owner_t         pick_owner;
  logic           pick_valid;

  logic [31:0]    gnt_addr;
  logic [31:0]    gnt_wd;
  logic           gnt_we;
  logic           gnt_blk;
  logic           gnt_oor;

  mem_arb_pick u_pick (
    .if_req (bus.IF_REQ),
    .d_req  (bus.D_REQ),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .owner  (pick_owner)
  );

`ifdef MEM_ARBITER_RR_EN
  owner_t rr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= OWN_IF;
    end else if ((state == IDLE) && pick_valid) begin
      rr_q <= pick_owner;
    end
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = OWN_IF;
`endif

  // Request fields of whichever side wins this IDLE cycle.
  always_comb begin
    gnt_addr = bus.IF_ADDR;
    gnt_wd   = '0;
    gnt_we   = 1'b0;
    gnt_blk  = 1'b0;
    gnt_oor  = 1'b0;
    if (pick_owner == OWN_D) begin
      gnt_addr = bus.D_ADDR;
      gnt_wd   = bus.D_WD;
      gnt_we   = bus.D_WE;
      gnt_oor  = (bus.D_ADDR >= 32'(DEPTH));
      gnt_blk  = bus.D_WE && store_blocked(bus.D_ADDR, IM_BASE, DEPTH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      blk_q    <= 1'b0;
      oor_q    <= 1'b0;
      wcnt     <= '0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      d_err_q  <= 1'b0;
      mwe_q    <= 1'b0;
      mra_q    <= '0;
      mwd_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_owner;
            we_q  <= gnt_we;
            blk_q <= gnt_blk;
            oor_q <= gnt_oor;
            wcnt  <= WC_INIT;
            mra_q <= gnt_addr;
            mwd_q <= gnt_wd;
            // A single-cycle access makes the first ACCESS cycle the write cycle.
            mwe_q <= (WAIT_CYCLES == 1) && gnt_we && !gnt_blk;
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (wcnt == '0) begin
            if (owner == OWN_D) begin
              d_rd_q  <= oor_q ? 32'h0 : bus.MRD;
              d_ack_q <= 1'b1;
              if (blk_q || oor_q) begin
                d_err_q <= 1'b1;
              end
            end else begin
              if_rd_q  <= bus.MRD;
              if_ack_q <= 1'b1;
            end
            mwe_q <= 1'b0;
            mra_q <= '0;
            mwd_q <= '0;
            state <= DONE;
          end else begin
            wcnt  <= wcnt - 1'b1;
            mwe_q <= (wcnt == WCW'(1)) && we_q && !blk_q;
          end
        end

        DONE: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Gating with RST keeps an abort from committing a write on the reset edge.
  assign bus.MWE    = mwe_q & ~RST;
  assign bus.MRA    = mra_q;
  assign bus.MWD    = mwd_q;
  assign bus.IF_ACK = if_ack_q;
  assign bus.IF_RD  = if_rd_q;
  assign bus.D_ACK  = d_ack_q;
  assign bus.D_RD   = d_rd_q;
  assign bus.D_ERR  = d_err_q;
  assign DBG_STATE  = state;

endmodule
